// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register that sits directly in front of the ALU. Each cycle it
// captures the decoded instruction and drives the registered ALU operands and
// control. RAW hazards are resolved by forwarding from EX and MEM before the
// register. A load followed by a dependent instruction is resolved by inserting
// one bubble and asking PC and IF/ID to hold.
//
// Ports
//   i_clk, i_reset              clock, asynchronous active-low reset
//   i_id_*                      decoded instruction from the ID stage
//   i_ex_result                 combinational ALU output of the instruction in EX
//   i_mem_reg_write/rd/result   write-back candidate from the MEM stage
//   i_stall                     global freeze; all registers hold
//   i_flush                     taken branch; the instruction entering EX dies
//   o_hazard_stall              load-use stall request to PC and IF/ID (comb.)
//   o_alu_in1/in2/fun/opcode/sign  registered ALU inputs
//   o_ex_store_data             forwarded rt, used as store data
//   o_ex_rd, o_ex_*             registered destination and downstream control
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_id_valid,
    input  logic [DATA_W-1:0] i_id_rs_data,
    input  logic [DATA_W-1:0] i_id_rt_data,
    input  logic [REG_AW-1:0] i_id_rs_addr,
    input  logic [REG_AW-1:0] i_id_rt_addr,
    input  logic [REG_AW-1:0] i_id_rd_addr,
    input  logic              i_id_uses_rs,
    input  logic              i_id_uses_rt,
    input  logic [DATA_W-1:0] i_id_imm,
    input  logic [4:0]        i_id_shamt,
    input  logic [1:0]        i_id_alusrc1,
    input  logic              i_id_alusrc2,
    input  logic [5:0]        i_id_alufun,
    input  logic [5:0]        i_id_opcode,
    input  logic              i_id_sign,
    input  logic              i_id_reg_write,
    input  logic              i_id_mem_read,
    input  logic              i_id_mem_write,
    input  logic              i_id_mem_to_reg,
    input  logic [DATA_W-1:0] i_ex_result,
    input  logic              i_mem_reg_write,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic [DATA_W-1:0] i_mem_result,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_hazard_stall,
    output logic [DATA_W-1:0] o_alu_in1,
    output logic [DATA_W-1:0] o_alu_in2,
    output logic [5:0]        o_alu_fun,
    output logic [5:0]        o_alu_opcode,
    output logic              o_alu_sign,
    output logic [DATA_W-1:0] o_ex_store_data,
    output logic [REG_AW-1:0] o_ex_rd,
    output logic              o_ex_valid,
    output logic              o_ex_reg_write,
    output logic              o_ex_mem_read,
    output logic              o_ex_mem_write,
    output logic              o_ex_mem_to_reg
);

    logic [DATA_W-1:0] r_alu_in1;
    logic [DATA_W-1:0] r_alu_in2;
    logic [5:0]        r_alu_fun;
    logic [5:0]        r_alu_opcode;
    logic              r_alu_sign;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_valid;
    logic              r_ex_reg_write;
    logic              r_ex_mem_read;
    logic              r_ex_mem_write;
    logic              r_ex_mem_to_reg;

    logic              w_ex_fwd_en;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;
    logic [DATA_W-1:0] w_in1;
    logic [DATA_W-1:0] w_in2;
    logic              w_rs_dep;
    logic              w_rt_dep;
    logic              w_hazard;
    logic              w_load_bubble;

    // A load in EX has no result yet, so it is never a forwarding source;
    // that case is covered by the load-use bubble instead.
    assign w_ex_fwd_en = r_ex_valid & r_ex_reg_write & ~r_ex_mem_read;

    // EX is younger than MEM, so it wins when both target the same register.
    // $0 is hard-wired, so it never forwards.
    always_comb begin
        w_fwd_rs = i_id_rs_data;
        if (i_id_rs_addr != '0) begin
            if (w_ex_fwd_en && (r_ex_rd == i_id_rs_addr)) begin
                w_fwd_rs = i_ex_result;
            end else if (i_mem_reg_write && (i_mem_rd == i_id_rs_addr)) begin
                w_fwd_rs = i_mem_result;
            end
        end
    end

    always_comb begin
        w_fwd_rt = i_id_rt_data;
        if (i_id_rt_addr != '0) begin
            if (w_ex_fwd_en && (r_ex_rd == i_id_rt_addr)) begin
                w_fwd_rt = i_ex_result;
            end else if (i_mem_reg_write && (i_mem_rd == i_id_rt_addr)) begin
                w_fwd_rt = i_mem_result;
            end
        end
    end

    // alusrc1 = 3 is unused by the decoder and falls back to rs.
    always_comb begin
        case (i_id_alusrc1)
            2'd1:    w_in1 = DATA_W'(i_id_shamt);
            2'd2:    w_in1 = DATA_W'({i_id_imm[15:0], 16'h0000});
            default: w_in1 = w_fwd_rs;
        endcase
    end

    assign w_in2 = i_id_alusrc2 ? i_id_imm : w_fwd_rt;

    assign w_rs_dep = i_id_uses_rs & (r_ex_rd == i_id_rs_addr);
    assign w_rt_dep = i_id_uses_rt & (r_ex_rd == i_id_rt_addr);

    // A flush kills the ID instruction anyway, so there is nothing to hold.
    assign w_hazard = i_id_valid & r_ex_valid & r_ex_mem_read & (r_ex_rd != '0)
                    & (w_rs_dep | w_rt_dep) & ~i_flush;

    // Flush beats the global freeze; a load-use bubble only happens when the
    // pipeline is actually advancing.
    assign w_load_bubble = i_flush | (~i_stall & w_hazard);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_alu_in1       <= '0;
            r_alu_in2       <= '0;
            r_alu_fun       <= '0;
            r_alu_opcode    <= '0;
            r_alu_sign      <= 1'b0;
            r_store_data    <= '0;
            r_ex_rd         <= '0;
            r_ex_valid      <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
        end else if (w_load_bubble) begin
            r_alu_in1       <= '0;
            r_alu_in2       <= '0;
            r_alu_fun       <= '0;
            r_alu_opcode    <= '0;
            r_alu_sign      <= 1'b0;
            r_store_data    <= '0;
            r_ex_rd         <= '0;
            r_ex_valid      <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
        end else if (!i_stall) begin
            r_alu_in1       <= w_in1;
            r_alu_in2       <= w_in2;
            r_alu_fun       <= i_id_alufun;
            r_alu_opcode    <= i_id_opcode;
            r_alu_sign      <= i_id_sign;
            r_store_data    <= w_fwd_rt;
            r_ex_rd         <= i_id_rd_addr;
            r_ex_valid      <= i_id_valid;
            r_ex_reg_write  <= i_id_valid & i_id_reg_write;
            r_ex_mem_read   <= i_id_valid & i_id_mem_read;
            r_ex_mem_write  <= i_id_valid & i_id_mem_write;
            r_ex_mem_to_reg <= i_id_valid & i_id_mem_to_reg;
        end
    end

    assign o_hazard_stall  = w_hazard;
    assign o_alu_in1       = r_alu_in1;
    assign o_alu_in2       = r_alu_in2;
    assign o_alu_fun       = r_alu_fun;
    assign o_alu_opcode    = r_alu_opcode;
    assign o_alu_sign      = r_alu_sign;
    assign o_ex_store_data = r_store_data;
    assign o_ex_rd         = r_ex_rd;
    assign o_ex_valid      = r_ex_valid;
    assign o_ex_reg_write  = r_ex_reg_write;
    assign o_ex_mem_read   = r_ex_mem_read;
    assign o_ex_mem_write  = r_ex_mem_write;
    assign o_ex_mem_to_reg = r_ex_mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Scoreboard bench for id_ex_stage. The stimulus process drives one ID
// instruction per cycle at the falling edge, runs it through a reference model
// of the EX-stage contents and pushes the expected hazard flag and the
// expected post-edge EX contents into queues. Two monitor processes pop and
// compare: the hazard flag shortly after the falling edge, the registered
// outputs shortly after the rising edge.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_id_valid;
    logic [31:0] i_id_rs_data, i_id_rt_data;
    logic [4:0]  i_id_rs_addr, i_id_rt_addr, i_id_rd_addr;
    logic        i_id_uses_rs, i_id_uses_rt;
    logic [31:0] i_id_imm;
    logic [4:0]  i_id_shamt;
    logic [1:0]  i_id_alusrc1;
    logic        i_id_alusrc2;
    logic [5:0]  i_id_alufun, i_id_opcode;
    logic        i_id_sign, i_id_reg_write, i_id_mem_read, i_id_mem_write, i_id_mem_to_reg;
    logic [31:0] i_ex_result;
    logic        i_mem_reg_write;
    logic [4:0]  i_mem_rd;
    logic [31:0] i_mem_result;
    logic        i_stall, i_flush;
    logic        o_hazard_stall;
    logic [31:0] o_alu_in1, o_alu_in2;
    logic [5:0]  o_alu_fun, o_alu_opcode;
    logic        o_alu_sign;
    logic [31:0] o_ex_store_data;
    logic [4:0]  o_ex_rd;
    logic        o_ex_valid, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_mem_to_reg;

    always #5 i_clk = ~i_clk;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_id_valid(i_id_valid),
        .i_id_rs_data(i_id_rs_data), .i_id_rt_data(i_id_rt_data),
        .i_id_rs_addr(i_id_rs_addr), .i_id_rt_addr(i_id_rt_addr), .i_id_rd_addr(i_id_rd_addr),
        .i_id_uses_rs(i_id_uses_rs), .i_id_uses_rt(i_id_uses_rt),
        .i_id_imm(i_id_imm), .i_id_shamt(i_id_shamt),
        .i_id_alusrc1(i_id_alusrc1), .i_id_alusrc2(i_id_alusrc2),
        .i_id_alufun(i_id_alufun), .i_id_opcode(i_id_opcode), .i_id_sign(i_id_sign),
        .i_id_reg_write(i_id_reg_write), .i_id_mem_read(i_id_mem_read),
        .i_id_mem_write(i_id_mem_write), .i_id_mem_to_reg(i_id_mem_to_reg),
        .i_ex_result(i_ex_result), .i_mem_reg_write(i_mem_reg_write),
        .i_mem_rd(i_mem_rd), .i_mem_result(i_mem_result),
        .i_stall(i_stall), .i_flush(i_flush),
        .o_hazard_stall(o_hazard_stall),
        .o_alu_in1(o_alu_in1), .o_alu_in2(o_alu_in2),
        .o_alu_fun(o_alu_fun), .o_alu_opcode(o_alu_opcode), .o_alu_sign(o_alu_sign),
        .o_ex_store_data(o_ex_store_data), .o_ex_rd(o_ex_rd), .o_ex_valid(o_ex_valid),
        .o_ex_reg_write(o_ex_reg_write), .o_ex_mem_read(o_ex_mem_read),
        .o_ex_mem_write(o_ex_mem_write), .o_ex_mem_to_reg(o_ex_mem_to_reg)
    );

    typedef struct {
        bit        valid;
        bit [31:0] rs_data, rt_data;
        bit [4:0]  rs, rt, rd;
        bit        use_rs, use_rt;
        bit [31:0] imm;
        bit [4:0]  shamt;
        bit [1:0]  src1;
        bit        src2;
        bit [5:0]  fun, opc;
        bit        sign, rw, mr, mw, m2r;
    } id_t;

    typedef struct {
        bit [31:0] ex_result, mem_result;
        bit        mem_rw;
        bit [4:0]  mem_rd;
        bit        stall, flush;
    } sd_t;

    // Contents of EX as the specification describes them; 'known' is cleared
    // for bubbles, whose datapath values are unspecified.
    typedef struct {
        bit        valid, rw, mr, mw, m2r, known;
        bit [31:0] in1, in2, sd;
        bit [5:0]  fun, opc;
        bit        sign;
        bit [4:0]  rd;
    } ex_t;

    ex_t m;
    ex_t exp_q[$];
    bit  hz_q[$];
    bit  last_hz;
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic id_t nop_id();
        id_t d;
        d = '{default: 0};
        return d;
    endfunction

    function automatic sd_t quiet();
        sd_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic ex_t bubble();
        ex_t b;
        b = '{default: 0};
        return b;
    endfunction

    // Value an instruction in ID sees for register a.
    function automatic bit [31:0] fwd(input ex_t cur, input bit [4:0] a, input bit [31:0] d, input sd_t s);
        if (a == 0) return d;
        if (cur.valid && cur.rw && !cur.mr && cur.rd == a) return s.ex_result;
        if (s.mem_rw && s.mem_rd == a) return s.mem_result;
        return d;
    endfunction

    function automatic ex_t step(input ex_t cur, input id_t d, input sd_t s, output bit hz);
        ex_t nx;
        bit [31:0] rs_v, rt_v;
        hz = !s.flush && d.valid && cur.valid && cur.mr && cur.rd != 0 &&
             ((d.use_rs && cur.rd == d.rs) || (d.use_rt && cur.rd == d.rt));
        if (s.flush) return bubble();
        if (s.stall) return cur;
        if (hz || !d.valid) return bubble();
        rs_v = fwd(cur, d.rs, d.rs_data, s);
        rt_v = fwd(cur, d.rt, d.rt_data, s);
        nx.valid = 1; nx.known = 1;
        nx.rw = d.rw; nx.mr = d.mr; nx.mw = d.mw; nx.m2r = d.m2r;
        if (d.src1 == 1)      nx.in1 = 32'(d.shamt);
        else if (d.src1 == 2) nx.in1 = d.imm[15:0] * 32'h0001_0000;
        else                  nx.in1 = rs_v;
        nx.in2  = d.src2 ? d.imm : rt_v;
        nx.sd   = rt_v;
        nx.fun  = d.fun;
        nx.opc  = d.opc;
        nx.sign = d.sign;
        nx.rd   = d.rd;
        return nx;
    endfunction

    task automatic cyc(input id_t d, input sd_t s);
        bit   hz;
        ex_t  nx;
        @(negedge i_clk);
        i_id_valid = d.valid;     i_id_rs_data = d.rs_data;  i_id_rt_data = d.rt_data;
        i_id_rs_addr = d.rs;      i_id_rt_addr = d.rt;       i_id_rd_addr = d.rd;
        i_id_uses_rs = d.use_rs;  i_id_uses_rt = d.use_rt;   i_id_imm = d.imm;
        i_id_shamt = d.shamt;     i_id_alusrc1 = d.src1;     i_id_alusrc2 = d.src2;
        i_id_alufun = d.fun;      i_id_opcode = d.opc;       i_id_sign = d.sign;
        i_id_reg_write = d.rw;    i_id_mem_read = d.mr;      i_id_mem_write = d.mw;
        i_id_mem_to_reg = d.m2r;
        i_ex_result = s.ex_result; i_mem_reg_write = s.mem_rw; i_mem_rd = s.mem_rd;
        i_mem_result = s.mem_result; i_stall = s.stall;        i_flush = s.flush;
        nx = step(m, d, s, hz);
        hz_q.push_back(hz);
        exp_q.push_back(nx);
        m = nx;
        last_hz = hz;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in1"},   o_alu_in1, 32'd0);
        chk({tag, "_in2"},   o_alu_in2, 32'd0);
        chk({tag, "_fun"},   32'(o_alu_fun), 32'd0);
        chk({tag, "_opc"},   32'(o_alu_opcode), 32'd0);
        chk({tag, "_sign"},  32'(o_alu_sign), 32'd0);
        chk({tag, "_sd"},    o_ex_store_data, 32'd0);
        chk({tag, "_rd"},    32'(o_ex_rd), 32'd0);
        chk({tag, "_valid"}, 32'(o_ex_valid), 32'd0);
        chk({tag, "_ctl"},   32'({o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_mem_to_reg}), 32'd0);
    endtask

    // Registered-output monitor.
    initial begin
        ex_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ex_valid",     32'(o_ex_valid),      32'(e.valid));
                chk("ex_reg_write", 32'(o_ex_reg_write),  32'(e.rw));
                chk("ex_mem_read",  32'(o_ex_mem_read),   32'(e.mr));
                chk("ex_mem_write", 32'(o_ex_mem_write),  32'(e.mw));
                chk("ex_mem_to_reg",32'(o_ex_mem_to_reg), 32'(e.m2r));
                if (e.known) begin
                    chk("alu_in1",    o_alu_in1,           e.in1);
                    chk("alu_in2",    o_alu_in2,           e.in2);
                    chk("store_data", o_ex_store_data,     e.sd);
                    chk("alu_fun",    32'(o_alu_fun),      32'(e.fun));
                    chk("alu_opcode", 32'(o_alu_opcode),   32'(e.opc));
                    chk("alu_sign",   32'(o_alu_sign),     32'(e.sign));
                    chk("ex_rd",      32'(o_ex_rd),        32'(e.rd));
                end
            end
        end
    end

    // Combinational hazard-flag monitor.
    initial begin
        bit h;
        forever begin
            @(negedge i_clk);
            #2;
            if (hz_q.size() > 0) begin
                h = hz_q.pop_front();
                chk("hazard_stall", 32'(o_hazard_stall), 32'(h));
            end
        end
    end

    initial begin
        id_t d;
        sd_t s;
        last_hz = 0;
        i_reset = 1'b0;
        d = nop_id();
        s = quiet();
        i_id_valid = 0; i_id_rs_data = 0; i_id_rt_data = 0; i_id_rs_addr = 0;
        i_id_rt_addr = 0; i_id_rd_addr = 0; i_id_uses_rs = 0; i_id_uses_rt = 0;
        i_id_imm = 0; i_id_shamt = 0; i_id_alusrc1 = 0; i_id_alusrc2 = 0;
        i_id_alufun = 0; i_id_opcode = 0; i_id_sign = 0; i_id_reg_write = 0;
        i_id_mem_read = 0; i_id_mem_write = 0; i_id_mem_to_reg = 0;
        i_ex_result = 0; i_mem_reg_write = 0; i_mem_rd = 0; i_mem_result = 0;
        i_stall = 0; i_flush = 0;
        m = bubble();
        m.known = 1;
        #2;
        chk_all_zero("por");
        @(negedge i_clk);
        i_reset = 1'b1;

        // add $3,$1,$2 then sub $4,$3,$2 forwarding rs from EX
        d = nop_id(); s = quiet();
        d.valid = 1; d.rs = 1; d.rt = 2; d.rd = 3; d.use_rs = 1; d.use_rt = 1;
        d.rs_data = 100; d.rt_data = 200; d.rw = 1; d.fun = 6'h00; d.opc = 6'h00;
        cyc(d, s);
        d.rs = 3; d.rd = 4; d.rs_data = 32'h55; d.rt_data = 5; d.fun = 6'h01;
        s.ex_result = 32'h0000_000A;
        cyc(d, s);
        #1 chk("exfwd_no_stall", 32'(o_hazard_stall), 32'd0);
        @(posedge i_clk); #1;
        chk("exfwd_in1", o_alu_in1, 32'h0000_000A);
        chk("exfwd_in2", o_alu_in2, 32'd5);

        // EX beats MEM on $3
        d = nop_id(); s = quiet();
        d.valid = 1; d.rs = 1; d.rd = 3; d.use_rs = 1; d.rw = 1;
        cyc(d, s);
        d.rs = 3; d.rd = 9; d.rs_data = 32'h11;
        s.ex_result = 7; s.mem_rw = 1; s.mem_rd = 3; s.mem_result = 9;
        cyc(d, s);
        @(posedge i_clk); #1;
        chk("prio_in1", o_alu_in1, 32'd7);

        // $0 never forwards even with EX rd=0 writing
        d = nop_id(); s = quiet();
        d.valid = 1; d.rs = 1; d.rd = 0; d.use_rs = 1; d.rw = 1;
        cyc(d, s);
        d.rs = 0; d.rs_data = 0; d.rd = 10;
        s.ex_result = 32'hDEAD; s.mem_rw = 1; s.mem_rd = 0; s.mem_result = 32'hBEEF;
        cyc(d, s);
        @(posedge i_clk); #1;
        chk("zero_src_in1", o_alu_in1, 32'd0);

        // lw $5 then add $6,$5,$1: one bubble, then MEM forward
        d = nop_id(); s = quiet();
        d.valid = 1; d.rs = 1; d.rd = 5; d.use_rs = 1; d.rw = 1; d.mr = 1; d.m2r = 1;
        d.src2 = 1; d.imm = 4;
        cyc(d, s);
        d = nop_id();
        d.valid = 1; d.rs = 5; d.rt = 1; d.rd = 6; d.use_rs = 1; d.use_rt = 1;
        d.rs_data = 32'h999; d.rt_data = 3; d.rw = 1;
        cyc(d, s);
        #1 chk("loaduse_stall", 32'(o_hazard_stall), 32'd1);
        @(posedge i_clk); #1;
        chk("loaduse_bubble", 32'(o_ex_valid), 32'd0);
        s.mem_rw = 1; s.mem_rd = 5; s.mem_result = 32'h1234;
        cyc(d, s);
        #1 chk("loaduse_one_cycle", 32'(o_hazard_stall), 32'd0);
        @(posedge i_clk); #1;
        chk("loaduse_in1", o_alu_in1, 32'h0000_1234);

        // flush and stall together load a bubble
        d = nop_id(); s = quiet();
        d.valid = 1; d.rs = 2; d.rd = 11; d.rw = 1; d.rs_data = 32'h42;
        s.stall = 1; s.flush = 1;
        cyc(d, s);
        @(posedge i_clk); #1;
        chk("flush_stall_valid", 32'(o_ex_valid), 32'd0);

        // capture, then stall alone for three cycles
        s = quiet();
        d.rs_data = 32'h77; d.use_rs = 1;
        cyc(d, s);
        for (int k = 0; k < 3; k++) begin
            d.rs_data = 32'h100 + 32'(k); d.rd = 5'(12 + k);
            s.stall = 1;
            cyc(d, s);
            @(posedge i_clk); #1;
            chk("stall_hold_in1", o_alu_in1, 32'h77);
        end

        // lui
        d = nop_id(); s = quiet();
        d.valid = 1; d.src1 = 2; d.src2 = 1; d.imm = 32'h0000_ABCD; d.opc = 6'h0F;
        d.rd = 7; d.rw = 1;
        cyc(d, s);
        @(posedge i_clk); #1;
        chk("lui_in1", o_alu_in1, 32'hABCD_0000);
        chk("lui_opc", 32'(o_alu_opcode), 32'h0F);

        // sll by 4
        d = nop_id();
        d.valid = 1; d.src1 = 1; d.shamt = 4; d.rt = 2; d.use_rt = 1; d.rt_data = 32'h31;
        d.rd = 8; d.rw = 1;
        cyc(d, s);
        @(posedge i_clk); #1;
        chk("sll_in1", o_alu_in1, 32'd4);
        chk("sll_in2", o_alu_in2, 32'h31);

        // asynchronous reset in the middle of a cycle
        d = nop_id();
        d.valid = 1; d.rs = 1; d.rs_data = 32'hCAFE; d.rd = 9; d.rw = 1; d.fun = 6'h22;
        cyc(d, s);
        @(posedge i_clk); #3;
        i_reset = 1'b0;
        #1 chk_all_zero("midrst");
        m = bubble();
        m.known = 1;
        @(posedge i_clk); #2;
        chk("rst_hold_valid", 32'(o_ex_valid), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        cyc(d, s);
        @(posedge i_clk); #1;
        chk("post_rst_valid", 32'(o_ex_valid), 32'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (!last_hz) begin
                d.valid   = ($urandom % 8) != 0;
                d.rs      = 5'($urandom % 4);
                d.rt      = 5'($urandom % 4);
                d.rd      = 5'($urandom % 4);
                d.use_rs  = 1'($urandom);
                d.use_rt  = 1'($urandom);
                d.rs_data = $urandom;
                d.rt_data = $urandom;
                d.imm     = $urandom;
                d.shamt   = 5'($urandom);
                d.src1    = 2'($urandom);
                d.src2    = 1'($urandom);
                d.fun     = 6'($urandom);
                d.opc     = 6'($urandom);
                d.sign    = 1'($urandom);
                d.rw      = 1'($urandom);
                d.mr      = ($urandom % 3) == 0;
                d.mw      = 1'($urandom);
                d.m2r     = 1'($urandom);
            end
            s.ex_result  = $urandom;
            s.mem_result = $urandom;
            s.mem_rw     = 1'($urandom);
            s.mem_rd     = 5'($urandom % 4);
            s.stall      = ($urandom % 10) == 0;
            s.flush      = ($urandom % 12) == 0;
            cyc(d, s);
        end

        repeat (3) @(negedge i_clk);
        chk("queue_drained", 32'(exp_q.size() + hz_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
